// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage core: latch enables/flushes, PC write enable,
// memory-wait and halt sequencing, plus saturating stall/flush counters for the debug path.

module hazard_ctrl_chk #(
   parameter int CNT_W = 16
) (
   input logic             CLK,
   input logic             RST,
   input logic             pc_en,
   input logic             ifid_enable,
   input logic             ifid_flush,
   input logic             idex_enable,
   input logic             idex_flush,
   input logic             exmem_enable,
   input logic             exmem_flush,
   input logic             memwb_enable,
   input logic             memwb_flush,
   input logic             halt,
   input logic [CNT_W-1:0] stall_cnt,
   input logic [CNT_W-1:0] flush_cnt
);

   logic any_en_s;
   logic any_fl_s;
   logic en_fl_clash_s;

   assign any_en_s = pc_en | ifid_enable | idex_enable | exmem_enable | memwb_enable;
   assign any_fl_s = ifid_flush | idex_flush | exmem_flush | memwb_flush;
   assign en_fl_clash_s = (ifid_enable & ifid_flush) | (idex_enable & idex_flush) |
                          (exmem_enable & exmem_flush) | (memwb_enable & memwb_flush);

   a_reset_squash: assert property (@(posedge CLK)
      RST |-> (!halt && !any_en_s && ifid_flush && idex_flush && exmem_flush && memwb_flush));

   a_halt_frozen: assert property (@(posedge CLK) disable iff (RST)
      halt |-> (!any_en_s && !any_fl_s));

   a_no_clash: assert property (@(posedge CLK) !en_fl_clash_s);

   // Counters only move upward between resets
   a_stall_mono: assert property (@(posedge CLK) disable iff (RST)
      !$past(RST) |-> (stall_cnt >= $past(stall_cnt)));

   a_flush_mono: assert property (@(posedge CLK) disable iff (RST)
      !$past(RST) |-> (flush_cnt >= $past(flush_cnt)));

endmodule

module hazard_ctrl #(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             exmem_dren,
   input  logic             exmem_dwen,
   input  logic             idex_dren,
   input  logic [REG_W-1:0] idex_rt,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             id_jump,
   input  logic             ex_branch_taken,
   input  logic             ex_jr,
   input  logic             memwb_halt,
   output logic             pc_en,
   output logic             ifid_enable,
   output logic             ifid_flush,
   output logic             idex_enable,
   output logic             idex_flush,
   output logic             exmem_enable,
   output logic             exmem_flush,
   output logic             memwb_enable,
   output logic             memwb_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DWAIT  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

   state_t           state_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   logic mem_op_s;
   logic ctl_flow_s;
   logic load_use_s;
   logic freeze_s;
   logic stall_inc_s;
   logic flush_inc_s;

   assign mem_op_s   = exmem_dren | exmem_dwen;
   assign ctl_flow_s = ex_branch_taken | ex_jr;
   // Register 0 is hardwired, so a load targeting it never creates a dependency
   assign load_use_s = idex_dren && (idex_rt != REG_ZERO) &&
                       ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

   // Freeze whenever a data access is outstanding, including the cycle the request first appears
   always_comb begin
      freeze_s = 1'b0;
      case (state_r)
         ST_RUN:   freeze_s = mem_op_s & ~dhit;
         ST_DWAIT: freeze_s = ~dhit;
         default:  freeze_s = 1'b0;
      endcase
   end

   // Latch controls, PC enable and counter increments from state plus current hazards
   always_comb begin
      pc_en        = 1'b0;
      ifid_enable  = 1'b0;
      ifid_flush   = 1'b0;
      idex_enable  = 1'b0;
      idex_flush   = 1'b0;
      exmem_enable = 1'b0;
      exmem_flush  = 1'b0;
      memwb_enable = 1'b0;
      memwb_flush  = 1'b0;
      halt         = 1'b0;
      stall_inc_s  = 1'b0;
      flush_inc_s  = 1'b0;
      if (RST) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
      end else begin
         case (state_r)
            ST_HALTED: begin
               halt = 1'b1;
            end
            ST_RUN, ST_DWAIT: begin
               if (freeze_s) begin
                  memwb_flush = 1'b1;
                  stall_inc_s = 1'b1;
               end else if (ctl_flow_s) begin
                  pc_en        = 1'b1;
                  ifid_flush   = 1'b1;
                  idex_flush   = 1'b1;
                  exmem_enable = 1'b1;
                  memwb_enable = 1'b1;
                  flush_inc_s  = 1'b1;
               end else if (load_use_s) begin
                  idex_flush   = 1'b1;
                  exmem_enable = 1'b1;
                  memwb_enable = 1'b1;
                  stall_inc_s  = 1'b1;
               end else if (id_jump) begin
                  pc_en        = 1'b1;
                  ifid_flush   = 1'b1;
                  idex_enable  = 1'b1;
                  exmem_enable = 1'b1;
                  memwb_enable = 1'b1;
                  flush_inc_s  = 1'b1;
               end else if (!ihit) begin
                  ifid_flush   = 1'b1;
                  idex_enable  = 1'b1;
                  exmem_enable = 1'b1;
                  memwb_enable = 1'b1;
                  stall_inc_s  = 1'b1;
               end else begin
                  pc_en        = 1'b1;
                  ifid_enable  = 1'b1;
                  idex_enable  = 1'b1;
                  exmem_enable = 1'b1;
                  memwb_enable = 1'b1;
               end
            end
            default: begin
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               memwb_flush = 1'b1;
            end
         endcase
      end
   end

   // State sequencing and saturating performance counters
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= ST_RUN;
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_RUN: begin
               if (memwb_halt) begin
                  state_r <= ST_HALTED;
               end else if (mem_op_s && !dhit) begin
                  state_r <= ST_DWAIT;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DWAIT: begin
               if (memwb_halt) begin
                  state_r <= ST_HALTED;
               end else if (dhit) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_DWAIT;
               end
            end
            ST_HALTED: state_r <= ST_HALTED;
            default:   state_r <= ST_RUN;
         endcase
         if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end
         if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
         end
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;

   hazard_ctrl_chk #(.CNT_W(CNT_W)) u_chk (
      .CLK          (CLK),
      .RST          (RST),
      .pc_en        (pc_en),
      .ifid_enable  (ifid_enable),
      .ifid_flush   (ifid_flush),
      .idex_enable  (idex_enable),
      .idex_flush   (idex_flush),
      .exmem_enable (exmem_enable),
      .exmem_flush  (exmem_flush),
      .memwb_enable (memwb_enable),
      .memwb_flush  (memwb_flush),
      .halt         (halt),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

endmodule
